// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ccff_bitstream_loader
//  Purpose  : Configuration-chain driver. Takes bitstream words over a
//             valid/ready port, shifts them LSB-first onto ccff_head for
//             exactly CHAIN_LEN enabled cycles, and returns the bits emerging
//             from ccff_tail as readback words over a second handshake.
//  Ports    : prog_clk/pReset  - clock, asynchronous active-low reset
//             start            - begins a load from IDLE or DONE
//             wr_data/valid/ready - bitstream word input (bit 0 first)
//             rb_data/valid/ready - readback word output (bit 0 first)
//             ccff_head/shift_en/tail - serial chain interface
//             busy / done      - load in progress / load finished
//  Revision : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 42,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
);

  localparam int               IDX_W     = $clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0] WORD_IDX  = IDX_W'(WORD_W);
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LEN_CNT   = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;   // completed shifts this load
  logic [IDX_W-1:0]  rb_idx_q, rb_idx_d;     // completed shifts into current rb word
  logic [IDX_W-1:0]  left_q, left_d;         // word bits not yet presented
  logic [WORD_W-1:0] sr_q, sr_d;             // remaining bitstream bits, LSB next
  logic [WORD_W-1:0] cap_q, cap_d;           // tail bits gathered so far
  logic              wr_ready_q, wr_ready_d;
  logic              rb_valid_q, rb_valid_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  w_remain;
  logic [IDX_W-1:0]  w_word_bits;
  logic [WORD_W-1:0] w_capture;
  logic              w_last_chain_bit;
  logic              w_rb_word_done;

  assign w_remain    = LEN_CNT - bit_cnt_q;
  assign w_word_bits = (w_remain >= CNT_W'(WORD_W)) ? WORD_IDX : w_remain[IDX_W-1:0];
  // Tail bit lands at rb_idx; higher bits stay zero because cap is cleared per word.
  assign w_capture   = cap_q | (WORD_W'(ccff_tail) << rb_idx_q);
  assign w_last_chain_bit = (bit_cnt_q == LEN_LAST);
  // shift_en_q high means the chain shifts (and tail is sampled) at this edge.
  assign w_rb_word_done   = shift_en_q & ((rb_idx_q == WORD_LAST) | w_last_chain_bit);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rb_idx_d   = rb_idx_q;
    left_d     = left_q;
    sr_d       = sr_q;
    cap_d      = cap_q;
    rb_valid_d = rb_valid_q;
    rb_data_d  = rb_data_q;
    head_d     = head_q;
    shift_en_d = 1'b0;

    // Readback side: release on handshake, load when a word completes.
    if (rb_valid_q && rb_ready) begin
      rb_valid_d = 1'b0;
    end
    if (shift_en_q) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (w_rb_word_done) begin
        rb_valid_d = 1'b1;
        rb_data_d  = w_capture;
        rb_idx_d   = '0;
        cap_d      = '0;
      end else begin
        rb_idx_d   = rb_idx_q + 1'b1;
        cap_d      = w_capture;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_FETCH;
          bit_cnt_d = '0;
          rb_idx_d  = '0;
          cap_d     = '0;
        end
      end
      ST_FETCH: begin
        if (wr_valid && wr_ready_q) begin
          sr_d    = wr_data;
          left_d  = w_word_bits;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (left_q != '0) begin
          // Present a new bit only when no readback word will be pending in
          // the next cycle, so the capture register is never overrun.
          if (!rb_valid_d) begin
            head_d     = sr_q[0];
            sr_d       = sr_q >> 1;
            left_d     = left_q - 1'b1;
            shift_en_d = 1'b1;
          end
        end else if (shift_en_q) begin
          state_d = w_last_chain_bit ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (rb_valid_q && rb_ready) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ready_d = (state_d == ST_FETCH);
    busy_d     = (state_d == ST_FETCH) || (state_d == ST_SHIFT) || (state_d == ST_DRAIN);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rb_idx_q   <= '0;
      left_q     <= '0;
      sr_q       <= '0;
      cap_q      <= '0;
      wr_ready_q <= 1'b0;
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rb_idx_q   <= rb_idx_d;
      left_q     <= left_d;
      sr_q       <= sr_d;
      cap_q      <= cap_d;
      wr_ready_q <= wr_ready_d;
      rb_valid_q <= rb_valid_d;
      rb_data_q  <= rb_data_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wr_ready      = wr_ready_q;
  assign rb_valid      = rb_valid_q;
  assign rb_data       = rb_data_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ccff_bitstream_loader
//  Purpose  : Self-checking bench for ccff_bitstream_loader with a behavioural
//             model of the configuration chain attached to head/tail.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_bitstream_loader;

  localparam int WW      = 32;
  localparam int CL      = 42;
  localparam int NW      = (CL + WW - 1) / WW;
  localparam int MIN_LAT = CL + 2 * NW + 2;

  logic          prog_clk = 1'b0;
  logic          pReset   = 1'b0;
  logic          start    = 1'b0;
  logic [WW-1:0] wr_data  = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [WW-1:0] rb_data;
  logic          rb_valid;
  logic          rb_ready = 1'b0;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.WORD_W(WW), .CHAIN_LEN(CL), .CNT_W(16)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done)
  );

  // Chain model: bit 0 leaves on tail, head enters at the far end.
  logic [CL-1:0] chain   = '0;
  logic [CL-1:0] pre_val = '0;
  logic          pre_req = 1'b0;
  always @(posedge prog_clk) begin
    if (pre_req)            chain <= pre_val;
    else if (ccff_shift_en) chain <= {ccff_head, chain[CL-1:1]};
  end
  assign ccff_tail = chain[0];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the chain ends up holding the bitstream bits in order.
  function automatic logic [CL-1:0] model_stream(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
    logic [2*WW-1:0] cat;
    cat = {w1, w0};
    return cat[CL-1:0];
  endfunction

  // Reference: readback word k is the previous chain contents, zero padded.
  function automatic logic [WW-1:0] model_rb(input logic [CL-1:0] prev, input int k);
    logic [WW-1:0] r;
    r = '0;
    for (int i = 0; i < WW; i++) begin
      if (k * WW + i < CL) r[i] = prev[k * WW + i];
    end
    return r;
  endfunction

  typedef struct {
    logic [WW-1:0] w0, w1;
    logic [CL-1:0] pre;
    int            gap, stall, start_at;
    logic [WW-1:0] exp_rb0, exp_rb1;
    logic [CL-1:0] exp_chain;
  } vec_t;

  vec_t tbl[8];

  // Results of the most recent load
  int            res_shifts, res_rb, res_acc, res_lat, res_rises, res_viol;
  logic [CL-1:0] res_heads;
  logic [WW-1:0] res_rb0, res_rb1;

  task automatic preload(input logic [CL-1:0] p);
    @(negedge prog_clk);
    pre_val = p;
    pre_req = 1'b1;
    @(negedge prog_clk);
    pre_req = 1'b0;
  endtask

  task automatic do_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                         input int gap, input int stall, input int start_at, input int reset_at);
    logic [WW-1:0] words[2];
    int            widx, gap_cnt, stall_cnt, cyc;
    logic          prev_head, prev_done, prev_rbv, prev_fire, did_start;
    logic [WW-1:0] prev_rbd;
    words[0] = w0; words[1] = w1;
    res_shifts = 0; res_rb = 0; res_acc = 0; res_lat = -1; res_rises = 0; res_viol = 0;
    res_heads = '0; res_rb0 = '0; res_rb1 = '0;
    widx = 0; gap_cnt = 0; stall_cnt = 0; cyc = 0; did_start = 1'b0;
    @(negedge prog_clk);
    start = 1'b1; wr_valid = 1'b1; wr_data = words[0]; rb_ready = (stall == 0);
    prev_head = ccff_head; prev_done = done; prev_rbv = 1'b0; prev_fire = 1'b0; prev_rbd = '0;
    while (cyc < 400 && (res_lat < 0 || cyc < res_lat + 4)) begin
      @(negedge prog_clk);
      cyc++;
      start = 1'b0;
      if (ccff_shift_en) begin
        if (res_shifts < CL) res_heads[res_shifts] = ccff_head;
        res_shifts++;
        if (!busy) res_viol++;
      end
      if (wr_ready && !busy) res_viol++;
      if (rb_valid && !rb_ready) begin
        if (ccff_shift_en || ccff_head !== prev_head) res_viol++;
        stall_cnt++;
      end
      if (prev_rbv && !prev_fire && (!rb_valid || rb_data !== prev_rbd)) res_viol++;
      if (widx == 1 && gap_cnt > 0 && (!wr_ready || ccff_shift_en)) res_viol++;
      if (widx == 1 && wr_ready && gap_cnt < gap) gap_cnt++;
      if (done && !prev_done) begin
        res_rises++;
        if (res_lat < 0) res_lat = cyc;
      end
      if (reset_at > 0 && res_shifts == reset_at) begin
        pReset = 1'b0;
        #1;
        check("async_reset_outputs",
              {wr_ready, rb_valid, rb_data, ccff_head, ccff_shift_en, busy, done}, 64'd0);
        @(negedge prog_clk);
        pReset = 1'b1;
        break;
      end
      // New inputs for the coming edge
      if (start_at > 0 && !did_start && res_shifts == start_at) begin
        start = 1'b1;
        did_start = 1'b1;
      end
      if (widx < 2) begin
        wr_valid = (widx == 0) || (gap_cnt >= gap);
        wr_data  = words[widx];
      end else begin
        wr_valid = 1'b1;
        wr_data  = $urandom;
      end
      rb_ready = (res_rb > 0) || (stall_cnt >= stall);
      if (wr_valid && wr_ready) begin
        res_acc++;
        widx++;
      end
      prev_fire = rb_valid && rb_ready;
      if (prev_fire) begin
        if (res_rb == 0) res_rb0 = rb_data;
        else if (res_rb == 1) res_rb1 = rb_data;
        res_rb++;
      end
      prev_rbv  = rb_valid;
      prev_rbd  = rb_data;
      prev_head = ccff_head;
      prev_done = done;
    end
    start = 1'b0;
  endtask

  task automatic check_load(input string tag, input logic [WW-1:0] e0, input logic [WW-1:0] e1,
                            input logic [CL-1:0] estream, input bit chk_lat);
    check({tag, "_done_seen"}, 64'(res_lat >= 0), 64'd1);
    check({tag, "_shift_count"}, 64'(res_shifts), 64'(CL));
    check({tag, "_head_seq"}, 64'(res_heads), 64'(estream));
    check({tag, "_rb_count"}, 64'(res_rb), 64'(NW));
    check({tag, "_rb0"}, 64'(res_rb0), 64'(e0));
    check({tag, "_rb1"}, 64'(res_rb1), 64'(e1));
    check({tag, "_chain_after"}, 64'(chain), 64'(estream));
    check({tag, "_words_taken"}, 64'(res_acc), 64'(NW));
    check({tag, "_done_rises"}, 64'(res_rises), 64'd1);
    check({tag, "_protocol"}, 64'(res_viol), 64'd0);
    check({tag, "_end_flags"}, {62'd0, done, busy}, 64'd2);
    if (chk_lat) check({tag, "_latency"}, 64'(res_lat), 64'(MIN_LAT));
  endtask

  initial begin
    logic [63:0]   tmp;
    logic [CL-1:0] snap;
    tbl[0] = '{w0: 32'hA5A5_A5A5, w1: 32'h0000_03FF, pre: 42'h2AB_CDEF_0123, gap: 0, stall: 0,
               start_at: 0, exp_rb0: 32'hCDEF_0123, exp_rb1: 32'h0000_02AB, exp_chain: 42'h3FF_A5A5_A5A5};
    tbl[1] = '{w0: 32'h1234_5678, w1: 32'hFFFF_FC00, pre: 42'h3FF_FFFF_FFFF, gap: 0, stall: 5,
               start_at: 0, exp_rb0: 32'hFFFF_FFFF, exp_rb1: 32'h0000_03FF, exp_chain: 42'h000_1234_5678};
    tbl[2] = '{w0: 32'h0000_0000, w1: 32'hFFFF_FFFF, pre: 42'h155_5555_5555, gap: 3, stall: 0,
               start_at: 0, exp_rb0: 32'h5555_5555, exp_rb1: 32'h0000_0155, exp_chain: 42'h3FF_0000_0000};
    tbl[3] = '{w0: 32'hDEAD_BEEF, w1: 32'h0000_0155, pre: 42'h0, gap: 0, stall: 0,
               start_at: 10, exp_rb0: 32'h0, exp_rb1: 32'h0, exp_chain: 42'h155_DEAD_BEEF};
    for (int i = 4; i < 8; i++) begin
      tbl[i].w0 = $urandom;
      tbl[i].w1 = $urandom;
      tmp = {$urandom, $urandom};
      tbl[i].pre = tmp[CL-1:0];
      tbl[i].gap = $urandom_range(0, 4);
      tbl[i].stall = $urandom_range(0, 6);
      tbl[i].start_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
      tbl[i].exp_rb0 = model_rb(tbl[i].pre, 0);
      tbl[i].exp_rb1 = model_rb(tbl[i].pre, 1);
      tbl[i].exp_chain = model_stream(tbl[i].w0, tbl[i].w1);
    end

    // Reset state
    repeat (3) @(negedge prog_clk);
    check("reset_outputs", {wr_ready, rb_valid, rb_data, ccff_head, ccff_shift_en, busy, done}, 64'd0);
    pReset = 1'b1;
    @(negedge prog_clk);
    check("idle_after_release", {62'd0, busy, done}, 64'd0);

    for (int v = 0; v < 8; v++) begin
      preload(tbl[v].pre);
      do_load(tbl[v].w0, tbl[v].w1, tbl[v].gap, tbl[v].stall, tbl[v].start_at, 0);
      check_load($sformatf("vec%0d", v), tbl[v].exp_rb0, tbl[v].exp_rb1, tbl[v].exp_chain,
                 tbl[v].gap == 0 && tbl[v].stall == 0);
    end

    // Abort mid-load, then a clean full load from whatever the chain holds.
    preload(42'h0F0_F0F0_F0F0);
    do_load(32'h8765_4321, 32'hABCD_EF01, 0, 0, 0, 20);
    check("abort_shift_count", 64'(res_shifts), 64'd20);
    repeat (3) @(negedge prog_clk);
    check("abort_stays_idle", {61'd0, busy, done, ccff_shift_en}, 64'd0);
    snap = chain;
    do_load(32'h0BAD_F00D, 32'h0000_0321, 0, 0, 0, 0);
    check_load("after_abort", model_rb(snap, 0), model_rb(snap, 1),
               model_stream(32'h0BAD_F00D, 32'h0000_0321), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain driver sitting directly upstream of the routing/CB tiles' `ccff_head` input.
- Accepts bitstream words over a valid/ready interface and serialises them onto `ccff_head`, one bit per enabled shift, for exactly CHAIN_LEN bits.
- Generates the shift enable that gates `prog_clk` for the whole chain.
- Captures the bits emerging from `ccff_tail` (the previous chain contents) and returns them as readback words with their own handshake.

Parameters:
- WORD_W, 32, bitstream/readback word width.
- CHAIN_LEN, 42, number of chain bits (7 muxes x 6 SRAM bits per tile); must be >= 1.
- CNT_W, 16, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  in  1  programming clock; only clock in the block.
- pReset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  single-cycle pulse that begins a load; ignored unless state is IDLE or DONE.
- wr_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  word accepted when wr_valid & wr_ready.
- rb_data  out  WORD_W  readback word; bit 0 is the first tail bit captured.
- rb_valid  out  1  readback word available.
- rb_ready  in  1  readback consumer ready.
- ccff_head  out  1  serial data into the chain.
- ccff_shift_en  out  1  chain clock-gate enable.
- ccff_tail  in  1  serial data out of the chain.
- busy  out  1  high in FETCH/SHIFT/DRAIN.
- done  out  1  high in DONE.

Behaviour:
- Reset values (pReset=0), asynchronous:
  - state=IDLE; counters and shift registers cleared.
  - wr_ready=0, rb_valid=0, rb_data=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0.
- Shift timing: all outputs are registered. With ccff_shift_en=1 in cycle n, the chain samples ccff_head and the loader samples ccff_tail at the rising edge ending cycle n. Whenever ccff_shift_en=0, the chain must not shift.
- States:
  - IDLE: start -> FETCH; bit_cnt=0.
  - FETCH: wr_ready=1.
    - On wr_valid & wr_ready: load the word into the shift register; word_bits = min(WORD_W, CHAIN_LEN - bit_cnt); -> SHIFT.
    - wr_ready falls on the cycle after acceptance.
  - SHIFT: each enabled cycle presents the next LSB on ccff_head and asserts ccff_shift_en. On that edge:
    - shift the tail bit into the readback register at position rb_idx;
    - increment bit_cnt and rb_idx.
  - SHIFT exits:
    - When rb_idx reaches WORD_W, or bit_cnt reaches CHAIN_LEN: raise rb_valid with rb_data held stable. rb_data bits above the last captured bit are 0.
    - While rb_valid=1 and rb_ready=0, the next shift is stalled (ccff_shift_en=0, ccff_head holds).
    - Word exhausted and bit_cnt < CHAIN_LEN -> FETCH.
    - bit_cnt = CHAIN_LEN -> DRAIN.
  - DRAIN: wait until the final readback word is accepted (rb_valid & rb_ready) -> DONE.
  - DONE: done=1 until the next start (-> FETCH, bit_cnt cleared, done falls the next cycle).
- Word bits above word_bits in the last (partial) word are discarded and never shifted.
- rb_valid/rb_data follow valid/ready rules: once raised, both are held until rb_ready. rb_valid falls the cycle after the handshake unless a new word completes in the same edge.
- Shifting stops exactly at CHAIN_LEN: ccff_shift_en is never high for more than CHAIN_LEN cycles per load.
- start while busy is ignored; no error flag.
- wr_valid outside FETCH is ignored; no word is consumed.
- pReset mid-load aborts immediately to reset values. The chain contents are undefined until the next full load.
- Total shift cycles per load = CHAIN_LEN. Minimum load latency from start to done = CHAIN_LEN + 2*ceil(CHAIN_LEN/WORD_W) + 2 cycles with wr_valid=1 and rb_ready=1 throughout.

Test Plan:
- Defaults, wr_valid/rb_ready tied 1, words 0xA5A5_A5A5 then 0x0000_03FF:
  - exactly 42 shift cycles; ccff_head sequence is LSB-first, 32 bits then 10 ones; upper 22 bits of word 2 unused.
  - 2 readback words; done rises once.
- Chain model preloaded with a 42-bit pattern P, then load:
  - rb word0 = P[31:0]; rb word1 = {22'b0, P[41:32]};
  - chain model afterwards holds the new bitstream.
- rb_ready held 0 for 5 cycles after word0 completes:
  - ccff_shift_en=0 and ccff_head stable for those cycles;
  - loading resumes with no lost or duplicated bits (total still 42).
- wr_valid dropped for 3 cycles in FETCH: wr_ready stays 1, no shifts occur; load completes correctly afterwards.
- start pulsed during SHIFT: ignored, bit_cnt continues; after DONE, a second start reloads cleanly from bit 0.
- pReset asserted after 20 shifts:
  - all outputs return to reset values asynchronously;
  - a new start performs a full 42-bit load.
